// File: rtl/traffic_phase_scheduler.sv
// Four-approach phase scheduler: latches vehicle/pedestrian requests and serves
// them round-robin through GREEN -> YELLOW -> ALL_RED with min/max/gap timing.
// All outputs are registered from the next-state values so they change on the
// same edge as the state they describe.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// GREEN    | active phase head shows green, walk lamp may be lit
// YELLOW   | active phase head shows yellow
// ALL_RED  | clearance interval, all heads red; next grant chosen on exit
module traffic_phase_scheduler #(
    parameter int TICK_W       = 8,
    parameter int MIN_GREEN    = 5,
    parameter int MAX_GREEN    = 20,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2,
    parameter int WALK_TIME    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [3:0]        veh_req,
    input  logic              ped_req_north,
    input  logic              ped_req_east,
    output logic [2:0]        north_lights,
    output logic [2:0]        north_left_lights,
    output logic [2:0]        east_lights,
    output logic [2:0]        east_left_lights,
    output logic              walk_north,
    output logic              walk_east,
    output logic [1:0]        active_phase,
    output logic [TICK_W-1:0] countdown
);

    typedef enum logic [1:0] {
        ST_GREEN   = 2'd0,
        ST_YELLOW  = 2'd1,
        ST_ALL_RED = 2'd2
    } state_t;

    localparam logic [2:0] HEAD_RED    = 3'b100;
    localparam logic [2:0] HEAD_YELLOW = 3'b010;
    localparam logic [2:0] HEAD_GREEN  = 3'b001;

    state_t            state, state_nxt;
    logic [TICK_W-1:0] timer, timer_nxt;
    logic [1:0]        phase_nxt;
    logic [3:0]        pending, pending_nxt;
    logic [1:0]        ped_pending, ped_pending_nxt;   // bit0 north, bit1 east
    logic              served, served_nxt;
    logic [3:0]        eff;
    logic [TICK_W:0]   timer_inc;
    logic              other;
    logic [1:0]        grant;
    logic              grant_found;
    logic [1:0]        scan_idx;
    logic              enter_green;
    logic [2:0]        head_n_nxt, head_nl_nxt, head_e_nxt, head_el_nxt;
    logic              walk_n_nxt, walk_e_nxt;
    logic [TICK_W-1:0] countdown_nxt;

    function automatic logic [2:0] head_for(input state_t st, input logic [1:0] ph,
                                            input logic [1:0] head);
        logic [2:0] v;
        v = HEAD_RED;
        if (ph == head) begin
            if (st == ST_GREEN)
                v = HEAD_GREEN;
            else if (st == ST_YELLOW)
                v = HEAD_YELLOW;
        end
        return v;
    endfunction

    // Next-state, request bookkeeping and next output values.
    always_comb begin
        eff       = {pending[3], pending[2] | ped_pending[1], pending[1], pending[0] | ped_pending[0]};
        timer_inc = {1'b0, timer} + 1'b1;
        other     = |(eff & ~(4'b0001 << active_phase));

        // Round-robin scan starting one past the current phase, wrapping to itself last.
        grant       = 2'd0;
        grant_found = 1'b0;
        scan_idx    = active_phase;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = active_phase + 2'(k);
            if (!grant_found && eff[scan_idx]) begin
                grant       = scan_idx;
                grant_found = 1'b1;
            end
        end

        state_nxt   = state;
        phase_nxt   = active_phase;
        enter_green = 1'b0;
        case (state)
            ST_GREEN: begin
                if (tick && other
                    && timer_inc >= (TICK_W+1)'(MIN_GREEN)
                    && (!veh_req[active_phase] || timer_inc >= (TICK_W+1)'(MAX_GREEN))
                    && (!served || timer >= TICK_W'(WALK_TIME)))
                    state_nxt = ST_YELLOW;
            end
            ST_YELLOW: begin
                if (tick && timer_inc == (TICK_W+1)'(YELLOW_TIME))
                    state_nxt = ST_ALL_RED;
            end
            ST_ALL_RED: begin
                if (tick && timer_inc == (TICK_W+1)'(ALL_RED_TIME)) begin
                    state_nxt   = ST_GREEN;
                    phase_nxt   = grant;
                    enter_green = 1'b1;
                end
            end
            default: state_nxt = ST_ALL_RED;
        endcase

        if (state_nxt != state)
            timer_nxt = '0;
        else if (tick && timer != {TICK_W{1'b1}})
            timer_nxt = timer + 1'b1;
        else
            timer_nxt = timer;

        // A clear on green entry overrides a set on the same edge.
        pending_nxt     = pending | veh_req;
        ped_pending_nxt = ped_pending | {ped_req_east, ped_req_north};
        served_nxt      = served;
        if (enter_green) begin
            pending_nxt[phase_nxt] = 1'b0;
            served_nxt             = 1'b0;
            if (phase_nxt == 2'd0) begin
                served_nxt         = ped_pending[0];
                ped_pending_nxt[0] = 1'b0;
            end else if (phase_nxt == 2'd2) begin
                served_nxt         = ped_pending[1];
                ped_pending_nxt[1] = 1'b0;
            end
        end

        head_n_nxt  = head_for(state_nxt, phase_nxt, 2'd0);
        head_nl_nxt = head_for(state_nxt, phase_nxt, 2'd1);
        head_e_nxt  = head_for(state_nxt, phase_nxt, 2'd2);
        head_el_nxt = head_for(state_nxt, phase_nxt, 2'd3);

        walk_n_nxt = (state_nxt == ST_GREEN) && (phase_nxt == 2'd0) && served_nxt
                     && (timer_nxt < TICK_W'(WALK_TIME));
        walk_e_nxt = (state_nxt == ST_GREEN) && (phase_nxt == 2'd2) && served_nxt
                     && (timer_nxt < TICK_W'(WALK_TIME));

        case (state_nxt)
            ST_GREEN:
                countdown_nxt = (timer_nxt >= TICK_W'(MAX_GREEN)) ? '0
                                : TICK_W'(MAX_GREEN) - timer_nxt;
            ST_YELLOW:
                countdown_nxt = TICK_W'(YELLOW_TIME) - timer_nxt;
            default:
                countdown_nxt = TICK_W'(ALL_RED_TIME) - timer_nxt;
        endcase
    end

    // State, timer, request latches and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_ALL_RED;
            active_phase      <= 2'd3;
            timer             <= '0;
            pending           <= '0;
            ped_pending       <= '0;
            served            <= 1'b0;
            north_lights      <= HEAD_RED;
            north_left_lights <= HEAD_RED;
            east_lights       <= HEAD_RED;
            east_left_lights  <= HEAD_RED;
            walk_north        <= 1'b0;
            walk_east         <= 1'b0;
            countdown         <= TICK_W'(ALL_RED_TIME);
        end else begin
            state             <= state_nxt;
            active_phase      <= phase_nxt;
            timer             <= timer_nxt;
            pending           <= pending_nxt;
            ped_pending       <= ped_pending_nxt;
            served            <= served_nxt;
            north_lights      <= head_n_nxt;
            north_left_lights <= head_nl_nxt;
            east_lights       <= head_e_nxt;
            east_left_lights  <= head_el_nxt;
            walk_north        <= walk_n_nxt;
            walk_east         <= walk_e_nxt;
            countdown         <= countdown_nxt;
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with short timing parameters.
module tb_traffic_phase_scheduler;

    localparam int TICK_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              tick;
    logic [3:0]        veh_req;
    logic              ped_req_north;
    logic              ped_req_east;
    logic [2:0]        north_lights, north_left_lights, east_lights, east_left_lights;
    logic              walk_north, walk_east;
    logic [1:0]        active_phase;
    logic [TICK_W-1:0] countdown;

    int n_assert = 0;
    int n_fail   = 0;

    traffic_phase_scheduler #(
        .TICK_W(TICK_W), .MIN_GREEN(3), .MAX_GREEN(6),
        .YELLOW_TIME(2), .ALL_RED_TIME(1), .WALK_TIME(4)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .veh_req(veh_req),
        .ped_req_north(ped_req_north), .ped_req_east(ped_req_east),
        .north_lights(north_lights), .north_left_lights(north_left_lights),
        .east_lights(east_lights), .east_left_lights(east_left_lights),
        .walk_north(walk_north), .walk_east(walk_east),
        .active_phase(active_phase), .countdown(countdown)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    int walk_cnt, green_cnt, walk_east_cnt, walk_outside, cyc;
    logic seen_green, done, prev_green, any_green;
    int grants, overlap, bad_onehot, nonred;
    logic [1:0] order [5];
    logic [1:0] exp_order [5];

    initial begin
        tick = 1'b1; veh_req = 4'b0; ped_req_north = 1'b0; ped_req_east = 1'b0;

        // Reset state and rest-in-green on N_THRU
        do_reset();
        reset = 1'b1;
        chk("rst_north", north_lights, 3'b100);
        chk("rst_north_left", north_left_lights, 3'b100);
        chk("rst_east", east_lights, 3'b100);
        chk("rst_east_left", east_left_lights, 3'b100);
        chk("rst_walks", {walk_north, walk_east}, 0);
        chk("rst_phase", active_phase, 3);
        chk("rst_countdown", countdown, 1);
        reset = 1'b0;
        step();
        chk("first_green", north_lights, 3'b001);
        chk("first_phase", active_phase, 0);
        chk("first_countdown", countdown, 6);
        repeat (30) step();
        chk("rest_green", north_lights, 3'b001);
        chk("rest_countdown", countdown, 0);
        chk("rest_east_red", east_lights, 3'b100);

        // Gap-out: green 3, yellow 2, all-red 1, then E_THRU
        do_reset();
        step();
        veh_req = 4'b0100;
        step();
        veh_req = 4'b0000;
        step();
        chk("gap_green3", north_lights, 3'b001);
        step();
        chk("gap_yellow1", north_lights, 3'b010);
        chk("gap_yellow1_cd", countdown, 2);
        step();
        chk("gap_yellow2", north_lights, 3'b010);
        chk("gap_yellow2_cd", countdown, 1);
        step();
        chk("gap_allred_n", north_lights, 3'b100);
        chk("gap_allred_e", east_lights, 3'b100);
        chk("gap_allred_cd", countdown, 1);
        step();
        chk("gap_east_green", east_lights, 3'b001);
        chk("gap_east_phase", active_phase, 2);
        chk("gap_east_cd", countdown, 6);
        chk("gap_north_red", north_lights, 3'b100);

        // Max-out with N_THRU detector held, E_LEFT requested
        veh_req = 4'b0001;
        do_reset();
        step();
        veh_req = 4'b1001;
        step();
        veh_req = 4'b0001;
        repeat (4) step();
        chk("max_green6", north_lights, 3'b001);
        step();
        chk("max_yellow", north_lights, 3'b010);
        step();
        step();
        chk("max_allred", north_lights, 3'b100);
        step();
        chk("max_grant_el", east_left_lights, 3'b001);
        chk("max_grant_phase", active_phase, 3);
        chk("max_nl_red", north_left_lights, 3'b100);
        chk("max_e_red", east_lights, 3'b100);

        // Pedestrian walk on north through green
        veh_req = 4'b0000;
        do_reset();
        step();
        veh_req = 4'b0100;
        step();
        veh_req = 4'b0000;
        repeat (5) step();
        chk("ped_east_green", east_lights, 3'b001);
        ped_req_north = 1'b1;
        veh_req = 4'b0010;
        step();
        ped_req_north = 1'b0;
        veh_req = 4'b0000;
        walk_cnt = 0; green_cnt = 0; walk_east_cnt = 0; walk_outside = 0;
        seen_green = 1'b0; done = 1'b0; cyc = 0;
        while (!done && cyc < 60) begin
            step();
            cyc++;
            if (walk_north) walk_cnt++;
            if (walk_east) walk_east_cnt++;
            if (walk_north && north_lights != 3'b001) walk_outside++;
            if (north_lights == 3'b001) begin
                green_cnt++;
                seen_green = 1'b1;
            end
            if (seen_green && north_lights == 3'b010) done = 1'b1;
        end
        chk("ped_reached_yellow", done, 1);
        chk("ped_walk_ticks", walk_cnt, 4);
        chk("ped_green_ge_walk", (green_cnt >= 4), 1);
        chk("ped_walk_east_off", walk_east_cnt, 0);
        chk("ped_walk_outside", walk_outside, 0);

        // Round-robin with all detectors held
        veh_req = 4'b1111;
        do_reset();
        exp_order[0] = 2'd0; exp_order[1] = 2'd1; exp_order[2] = 2'd2;
        exp_order[3] = 2'd3; exp_order[4] = 2'd0;
        grants = 0; overlap = 0; bad_onehot = 0; prev_green = 1'b0; cyc = 0;
        while (grants < 5 && cyc < 200) begin
            step();
            cyc++;
            nonred = (north_lights != 3'b100) + (north_left_lights != 3'b100)
                   + (east_lights != 3'b100) + (east_left_lights != 3'b100);
            if (nonred > 1) overlap++;
            if ($countones(north_lights) != 1 || $countones(north_left_lights) != 1 ||
                $countones(east_lights) != 1 || $countones(east_left_lights) != 1)
                bad_onehot++;
            any_green = north_lights[0] | north_left_lights[0] | east_lights[0] | east_left_lights[0];
            if (any_green && !prev_green) begin
                order[grants] = active_phase;
                grants++;
            end
            prev_green = any_green;
        end
        chk("rr_grants", grants, 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);
        chk("rr_overlap", overlap, 0);
        chk("rr_onehot", bad_onehot, 0);

        // Reset during yellow, then tick held low
        veh_req = 4'b0000;
        do_reset();
        step();
        veh_req = 4'b0100;
        step();
        veh_req = 4'b0000;
        step();
        step();
        chk("ry_in_yellow", north_lights, 3'b010);
        reset = 1'b1;
        tick = 1'b0;
        step();
        chk("ry_north_red", north_lights, 3'b100);
        chk("ry_east_red", east_lights, 3'b100);
        chk("ry_phase", active_phase, 3);
        reset = 1'b0;
        veh_req = 4'b0010;
        step();
        veh_req = 4'b0000;
        repeat (9) step();
        chk("ry_hold_nl", north_left_lights, 3'b100);
        chk("ry_hold_n", north_lights, 3'b100);
        chk("ry_hold_cd", countdown, 1);
        chk("ry_hold_phase", active_phase, 3);
        tick = 1'b1;
        step();
        chk("ry_resume_nl", north_left_lights, 3'b001);
        chk("ry_resume_phase", active_phase, 1);
        chk("ry_resume_n", north_lights, 3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Phase scheduler for the four-approach intersection. It owns the north through, north left, east through and east left signal heads, plus the north and east pedestrian walk lamps. It latches vehicle and pedestrian requests and serves them round-robin through GREEN -> YELLOW -> ALL_RED sequencing, with min-green, max-green and gap-out timing. It exports the active phase and a remaining-time count for the 7-segment display driver.

Parameters:
TICK_W, 8, width of the phase timer and countdown in ticks
MIN_GREEN, 5, minimum green ticks per phase
MAX_GREEN, 20, maximum green ticks while another phase is pending
YELLOW_TIME, 3, yellow ticks
ALL_RED_TIME, 2, all-red clearance ticks
WALK_TIME, 4, walk-lamp ticks at the start of a through green

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
tick  input  1  one-cycle timing strobe; all timers advance only on tick
veh_req  input  4  vehicle detector levels; bit0 N_THRU, bit1 N_LEFT, bit2 E_THRU, bit3 E_LEFT
ped_req_north  input  1  north pedestrian button level
ped_req_east  input  1  east pedestrian button level
north_lights  output  3  {red,yellow,green}
north_left_lights  output  3  {red,yellow,green}
east_lights  output  3  {red,yellow,green}
east_left_lights  output  3  {red,yellow,green}
walk_north  output  1  north walk lamp
walk_east  output  1  east walk lamp
active_phase  output  2  phase currently or last granted
countdown  output  TICK_W  ticks remaining in the current interval

Behaviour:
- One clock, clk. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - state=ALL_RED, active_phase=3, timer=0.
  - pending=0, ped_pending=0.
  - All heads = 3'b100 (red); walk_north=walk_east=0; countdown=ALL_RED_TIME.
- Request latching, every cycle:
  - pending[i] |= veh_req[i].
  - ped_pending[N] |= ped_req_north; ped_pending[E] |= ped_req_east.
  - On GREEN entry, pending[p] is cleared. ped_pending for p is cleared on the same edge when p is N_THRU or E_THRU.
  - Set and clear on the same edge: clear wins, then the set applies next cycle if the input is still high.
- Effective request: eff[0]=pending[0]|ped_pending[N]; eff[2]=pending[2]|ped_pending[E]; eff[1], eff[3] = pending bits.
- States:
  - GREEN: the active head shows 001; all others show 100.
  - YELLOW: the active head shows 010.
  - ALL_RED: all heads show 100.
- Timer: cleared on every state entry; increments on tick and saturates at 2^TICK_W-1.
- GREEN -> YELLOW, evaluated on a tick edge. Let other = any eff[j] with j != p. Exit when other AND timer+1 >= MIN_GREEN AND one of:
  - veh_req[p]==0 (gap-out), or
  - timer+1 >= MAX_GREEN (max-out).
- Rest-in-green: with no other request, GREEN holds indefinitely. Countdown holds at MAX_GREEN-min(timer,MAX_GREEN).
- YELLOW -> ALL_RED: when timer+1 == YELLOW_TIME on tick.
- ALL_RED -> GREEN:
  - Transition when timer+1 == ALL_RED_TIME on tick.
  - Next phase = first eff bit set scanning active_phase+1, +2, +3, +0 (mod 4).
  - If none is set, next phase = 0 (N_THRU).
  - active_phase updates on this edge.
- Walk lamps:
  - walk_north=1 while GREEN on N_THRU, timer < WALK_TIME, and a ped request was latched at that phase's GREEN entry (held in a served flag).
  - walk_east behaves the same for E_THRU.
  - A walk-served green does not leave GREEN before timer >= WALK_TIME, regardless of MIN_GREEN.
- Countdown:
  - YELLOW: YELLOW_TIME-timer.
  - ALL_RED: ALL_RED_TIME-timer.
  - GREEN: as above.
- Simultaneous requests: at most one phase is green. Order is strictly round-robin; a phase cannot be re-granted until the scan passes it.
- tick=0: no timer advance and no state change. Requests still latch.
- Reset mid-green or mid-yellow: heads drop to red on the next edge, with no yellow.
- Exactly one of R/Y/G is set per head at all times. Walk is never asserted outside its through green.

Test Plan:
- Use MIN_GREEN=3, MAX_GREEN=6, YELLOW_TIME=2, ALL_RED_TIME=1, WALK_TIME=4, tick tied high.
- Reset 2 cycles, no requests -> all 100 during reset. One tick after release N_THRU=001, active_phase=0; N_THRU rests green for 30 cycles.
- N_THRU green, veh_req=4'b0100 held 1 cycle, veh_req[0]=0 -> green lasts exactly 3 ticks, yellow 2, all-red 1. E_THRU=001, active_phase=2, countdown=6 on entry.
- veh_req[0] held high, veh_req[3] pulsed -> max-out: N_THRU yellow after 6 green ticks; next grant is E_LEFT (3), skipping 1 and 2.
- ped_req_north pulsed during E_THRU green -> next N_THRU green has walk_north=1 for 4 ticks and green lasts at least 4 ticks. walk_east stays 0.
- veh_req=4'b1111 held from reset -> grant order 0,1,2,3,0. No two heads non-red in the same cycle.
- Assert reset during YELLOW, then tick held low for 10 cycles -> all heads 100 on the next edge and no state advance until tick returns.
